ram_2ch_ctrl: RTL and testbench
===============================

# ram_2ch_ctrl

Parametrised two-channel RAM block and successor to the fixed 64Kx8 RAM wrapper, with configurable width, depth and access wait states. It serialises requests from two masters, such as the CPU and the video fetch, through a round-robin arbiter. It runs a req/ack handshake per channel. It sits between bus masters and the storage array in the memory subsystem.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: address width in bits; the array holds 2^DEPTH words.
- WAIT, 0: extra wait cycles inserted before each array access (0..15).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high (one clock; fixed polarity/synchronicity).
- i_a_req  in  1  channel A request; held high until o_a_ack.
- i_a_write  in  1  channel A: 1 = write, 0 = read.
- i_a_addr  in  DEPTH  channel A address.
- i_a_data  in  WIDTH  channel A write data.
- o_a_ack  out  1  channel A one-cycle completion pulse.
- o_a_data  out  WIDTH  channel A read data.
- i_b_req, i_b_write, i_b_addr, i_b_data, o_b_ack, o_b_data: same as channel A, for channel B.
- o_busy  out  1  high while the memory-clear sweep runs (RAM_CLEAR_EN only).

## Operation
- Three-state FSM: IDLE, RUN, ACK. CLEAR is a fourth state, present only when RAM_CLEAR_EN is defined.
- IDLE:
  - If any req is high, grant one channel.
  - Latch its write flag, address and data into internal registers.
  - Load the wait counter with WAIT. Go to RUN.
- Arbitration: round-robin.
  - When both reqs are high, grant the channel not granted last.
  - After reset, last-granted = B, so A wins the first tie.
- RUN:
  - If the counter ≠ 0, decrement it.
  - If the counter = 0, perform the array access at this edge and go to ACK.
    - Write: the array word takes the latched data.
    - Read: the granted o_x_data takes the array word.
- ACK: the granted o_x_ack is high for exactly this cycle. Next state is IDLE.
- Masters drop req in the ACK cycle or the following one. A req still high in the IDLE cycle after ACK is a new request.
- Requester inputs must be stable from req rise until ack. The controller samples them only on the IDLE→RUN edge.
- o_x_data holds its value until the next read on the same channel. Writes and the other channel's reads leave it unchanged.
- Reset values: o_a_ack = o_b_ack = 0, o_a_data = o_b_data = 0, FSM = IDLE (CLEAR with the macro), last-granted = B, counter = 0.
- The array contents are not touched by reset (without the macro).
- Reset mid-operation:
  - FSM aborts immediately and no ack is issued.
  - If rst is high on the RUN access edge, the write is not performed.
- Wait counter width: clog2(WAIT+1), minimum 1 bit. WAIT = 0 is legal.

## Timing
- Request seen in IDLE at cycle t:
  - RUN occupies cycles t+1 .. t+1+WAIT.
  - Ack and read data are valid in cycle t+2+WAIT.
- Throughput: one access per WAIT+3 cycles, including the IDLE turnaround.
- A losing channel waits one full access of the other channel, then is granted in the next IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- RAM_CLEAR_EN defined:
  - On rst, the FSM enters CLEAR, with o_busy = 1 and the sweep address = 0.
  - Each cycle after rst falls, zero is written to one address, ascending.
  - The sweep takes 2^DEPTH cycles, then o_busy = 0 and the FSM goes to IDLE.
  - Reqs raised during CLEAR stay pending and are served afterwards.
  - rst during the sweep restarts it at address 0.
- RAM_CLEAR_EN undefined:
  - No CLEAR state; o_busy is tied to 0.
  - Array contents after power-up are undefined (X in simulation).

## Structure
- Package ram_pkg:
  - FSM state enum (IDLE, RUN, ACK, CLEAR).
  - Channel-select constants CH_A/CH_B.
  - Wait-counter width function.
- One sub-module, ram_core_sp: single-port synchronous array parametrised by WIDTH/DEPTH, with registered read and write enable. The controller instantiates it once; the clear sweep drives its port through the same mux.

## Test plan
- WIDTH=8, DEPTH=4, WAIT=0: A writes 0x5A to addr 3, then A reads addr 3 → o_a_ack 2 cycles after req, o_a_data = 0x5A.
- WAIT=2: B reads an address holding 0xC3 → o_b_ack exactly 4 cycles after req sampled, one-cycle pulse, o_b_data = 0xC3.
- A and B req in the same cycle after reset (A writes 0x11 @1, B writes 0x22 @2) → A acked first, B acked WAIT+3 cycles later. Next tie → B first.
- Back-to-back: A holds req through the ACK cycle → second access starts in the following IDLE, and one extra write occurs (checked by counting acks = 2).
- rst pulsed during RUN of an A write of 0xFF to addr 5 → no ack, addr 5 unchanged; outputs return to reset values.
- RAM_CLEAR_EN, DEPTH=4: o_busy high for 16 cycles after rst falls. A req raised at cycle 3 is acked after busy drops. Reads of all 16 addresses return 0x00.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the two-channel RAM controller.
// Optional memory-clear sweep is enabled with RAM_CLEAR_EN.
package ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StAck,
    StClear
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Wait-counter width; never narrower than one bit so WAIT = 0 still has a counter.
  function automatic int unsigned cnt_width(int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/ram_2ch_ctrl_if.sv
// Two-channel req/ack memory bus between masters and ram_2ch_ctrl.
interface ram_2ch_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  logic             i_a_req;
  logic             i_a_write;
  logic [DEPTH-1:0] i_a_addr;
  logic [WIDTH-1:0] i_a_data;
  logic             o_a_ack;
  logic [WIDTH-1:0] o_a_data;

  logic             i_b_req;
  logic             i_b_write;
  logic [DEPTH-1:0] i_b_addr;
  logic [WIDTH-1:0] i_b_data;
  logic             o_b_ack;
  logic [WIDTH-1:0] o_b_data;

  logic             o_busy;

  modport master (
    output i_a_req, i_a_write, i_a_addr, i_a_data,
    output i_b_req, i_b_write, i_b_addr, i_b_data,
    input  o_a_ack, o_a_data, o_b_ack, o_b_data, o_busy
  );

  modport slave (
    input  i_a_req, i_a_write, i_a_addr, i_a_data,
    input  i_b_req, i_b_write, i_b_addr, i_b_data,
    output o_a_ack, o_a_data, o_b_ack, o_b_data, o_busy
  );
endinterface

// File: rtl/ram_core_sp.sv
// Single-port synchronous RAM array with write enable and registered read.
module ram_core_sp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [DEPTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/ram_2ch_ctrl.sv
// Two-channel round-robin RAM controller with configurable wait states.
// Define RAM_CLEAR_EN to zero the array after every reset.
module ram_2ch_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WAIT  = 0
) (
  input logic           clk,
  input logic           rst,
  ram_2ch_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WAIT);
  localparam logic [CntW-1:0] WaitLd = CntW'(WAIT);

  state_t           state_q;
  logic             last_q;
  logic             grant_q;
  logic             write_q;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] data_q;
  logic [CntW-1:0]  cnt_q;
  logic             a_ack_q, b_ack_q;
  logic [WIDTH-1:0] a_hold_q, b_hold_q;
`ifdef RAM_CLEAR_EN
  logic             busy_q;
  logic [DEPTH-1:0] clr_addr_q;
`endif

  logic             sel;
  logic             access;
  logic             core_we, core_re;
  logic [DEPTH-1:0] core_addr;
  logic [WIDTH-1:0] core_wdata;
  logic [WIDTH-1:0] core_rdata;

  // B wins only if A is idle or A was granted last.
  assign sel    = bus.i_b_req && (!bus.i_a_req || last_q == CH_A);
  assign access = (state_q == StRun) && (cnt_q == '0) && !rst;

  always_comb begin
    core_we    = access & write_q;
    core_re    = access & ~write_q;
    core_addr  = addr_q;
    core_wdata = data_q;
`ifdef RAM_CLEAR_EN
    if (state_q == StClear && !rst) begin
      core_we    = 1'b1;
      core_re    = 1'b0;
      core_addr  = clr_addr_q;
      core_wdata = '0;
    end
`endif
  end

  ram_core_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk_i   (clk),
    .we_i    (core_we),
    .re_i    (core_re),
    .addr_i  (core_addr),
    .wdata_i (core_wdata),
    .rdata_o (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_CLEAR_EN
      state_q    <= StClear;
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
`else
      state_q    <= StIdle;
`endif
      last_q     <= CH_B;
      grant_q    <= CH_A;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.i_a_req || bus.i_b_req) begin
            grant_q <= sel;
            last_q  <= sel;
            write_q <= (sel == CH_B) ? bus.i_b_write : bus.i_a_write;
            addr_q  <= (sel == CH_B) ? bus.i_b_addr  : bus.i_a_addr;
            data_q  <= (sel == CH_B) ? bus.i_b_data  : bus.i_a_data;
            cnt_q   <= WaitLd;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= StAck;
            if (grant_q == CH_A) a_ack_q <= 1'b1;
            else                 b_ack_q <= 1'b1;
          end
        end
        StAck: begin
          state_q <= StIdle;
          // Capture the read word so the channel keeps it after the ack.
          if (!write_q) begin
            if (grant_q == CH_A) a_hold_q <= core_rdata;
            else                 b_hold_q <= core_rdata;
          end
        end
`ifdef RAM_CLEAR_EN
        StClear: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // During the ack cycle the read word comes straight from the core's output register.
  assign bus.o_a_ack  = a_ack_q;
  assign bus.o_b_ack  = b_ack_q;
  assign bus.o_a_data = (a_ack_q && !write_q) ? core_rdata : a_hold_q;
  assign bus.o_b_data = (b_ack_q && !write_q) ? core_rdata : b_hold_q;
`ifdef RAM_CLEAR_EN
  assign bus.o_busy   = busy_q;
`else
  assign bus.o_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_2ch_ctrl.sv
// Scoreboard bench for ram_2ch_ctrl: one WAIT=0 and one WAIT=2 instance, DEPTH=4.
module tb_ram_2ch_ctrl;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst2 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Channel index: 0 = dut0.A, 1 = dut0.B, 2 = dut2.A, 3 = dut2.B
  logic       req  [4];
  logic       wr   [4];
  logic [3:0] addr [4];
  logic [7:0] wdat [4];
  logic       ack  [4];
  logic [7:0] rdat [4];
  logic       busy0, busy2;
  logic       prev_ack [4];
  exp_t       sb [4][$];

  ram_2ch_ctrl_if #(.WIDTH(8), .DEPTH(4)) if0 ();
  ram_2ch_ctrl_if #(.WIDTH(8), .DEPTH(4)) if2 ();

  ram_2ch_ctrl #(.WIDTH(8), .DEPTH(4), .WAIT(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  ram_2ch_ctrl #(.WIDTH(8), .DEPTH(4), .WAIT(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  assign if0.i_a_req = req[0];  assign if0.i_a_write = wr[0];
  assign if0.i_a_addr = addr[0]; assign if0.i_a_data = wdat[0];
  assign if0.i_b_req = req[1];  assign if0.i_b_write = wr[1];
  assign if0.i_b_addr = addr[1]; assign if0.i_b_data = wdat[1];
  assign if2.i_a_req = req[2];  assign if2.i_a_write = wr[2];
  assign if2.i_a_addr = addr[2]; assign if2.i_a_data = wdat[2];
  assign if2.i_b_req = req[3];  assign if2.i_b_write = wr[3];
  assign if2.i_b_addr = addr[3]; assign if2.i_b_data = wdat[3];
  assign ack[0] = if0.o_a_ack;  assign rdat[0] = if0.o_a_data;
  assign ack[1] = if0.o_b_ack;  assign rdat[1] = if0.o_b_data;
  assign ack[2] = if2.o_a_ack;  assign rdat[2] = if2.o_a_data;
  assign ack[3] = if2.o_b_ack;  assign rdat[3] = if2.o_b_data;
  assign busy0 = if0.o_busy;
  assign busy2 = if2.o_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the matching channel's expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (ack[i] === 1'b1) begin
        chk($sformatf("ack_pulse_ch%0d", i), int'(prev_ack[i] === 1'b1), 0);
        if (sb[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack_ch%0d: got ack expected none (cycle %0d)", i, cyc);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("ack_cycle_ch%0d", i), cyc, e.at);
          if (e.rd) chk($sformatf("rdata_ch%0d", i), int'(rdat[i]), int'(e.data));
        end
      end
      prev_ack[i] = ack[i];
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(int idx, logic rd, logic [7:0] d, int at);
    exp_t e;
    e.rd = rd; e.data = d; e.at = at;
    sb[idx].push_back(e);
  endtask

  // Master: hold req until n_acks acks have been seen, then drop it in the ack cycle.
  task automatic access(int idx, logic w, logic [3:0] a, logic [7:0] d, int n_acks);
    int seen = 0;
    int budget = 0;
    wr[idx] = w; addr[idx] = a; wdat[idx] = d; req[idx] = 1'b1;
    while (seen < n_acks && budget < 100) begin
      @(negedge clk);
      budget++;
      if (ack[idx] === 1'b1) seen++;
    end
    req[idx] = 1'b0;
    if (seen < n_acks) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout_ch%0d: got %0d acks expected %0d", idx, seen, n_acks);
    end
  endtask

  task automatic op(int idx, logic w, logic [3:0] a, logic [7:0] d, int lat);
    sync();
    expect_ack(idx, !w, d, cyc + lat);
    access(idx, w, a, d, 1);
  endtask

  task automatic wait_clear(bit do_chk);
`ifdef RAM_CLEAR_EN
    int n = 0;
    for (int b = 0; b < 200 && (busy0 || busy2); b++) begin
      @(negedge clk);
      if (busy0) n++;
    end
    if (do_chk) chk("busy_cycles", n, 16);
`else
    if (do_chk) chk("busy_tied_low", int'(busy0 | busy2), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0; prev_ack[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ack_ch%0d", i), int'(ack[i]), 0);
      chk($sformatf("reset_data_ch%0d", i), int'(rdat[i]), 0);
    end
    wait_clear(1'b1);

`ifdef RAM_CLEAR_EN
    for (int a = 0; a < 16; a++) op(0, 1'b0, 4'(a), 8'h00, 2);
`endif

    // First tie after reset: A then B, WAIT+3 apart.
    sync();
    expect_ack(0, 1'b0, 8'h00, cyc + 2);
    expect_ack(1, 1'b0, 8'h00, cyc + 5);
    fork
      access(0, 1'b1, 4'd1, 8'h11, 1);
      access(1, 1'b1, 4'd2, 8'h22, 1);
    join
    op(0, 1'b0, 4'd1, 8'h11, 2);
    op(0, 1'b0, 4'd2, 8'h22, 2);

    // WAIT=0 write then read.
    op(0, 1'b1, 4'd3, 8'h5A, 2);
    op(0, 1'b0, 4'd3, 8'h5A, 2);

    // A was granted last, so this tie goes to B.
    sync();
    expect_ack(1, 1'b0, 8'h00, cyc + 2);
    expect_ack(0, 1'b0, 8'h00, cyc + 5);
    fork
      access(0, 1'b1, 4'd1, 8'h33, 1);
      access(1, 1'b1, 4'd2, 8'h44, 1);
    join
    op(0, 1'b0, 4'd1, 8'h33, 2);
    op(0, 1'b0, 4'd2, 8'h44, 2);

    // Req held through ACK: a second access starts in the next IDLE.
    sync();
    expect_ack(0, 1'b0, 8'h00, cyc + 2);
    expect_ack(0, 1'b0, 8'h00, cyc + 5);
    access(0, 1'b1, 4'd9, 8'h5C, 2);
    op(0, 1'b0, 4'd9, 8'h5C, 2);

    // WAIT=2 instance: B reads a word written by A; B's data survives A traffic.
    op(2, 1'b1, 4'd7, 8'hC3, 4);
    op(3, 1'b0, 4'd7, 8'hC3, 4);
    op(2, 1'b1, 4'd7, 8'h99, 4);
    chk("b_hold_after_a_write", int'(rdat[3]), 'hC3);
    op(2, 1'b0, 4'd7, 8'h99, 4);
    chk("b_hold_after_a_read", int'(rdat[3]), 'hC3);
    op(2, 1'b1, 4'd5, 8'h77, 4);

    // Reset asserted on the access edge of an A write.
    sync();
    wr[2] = 1'b1; addr[2] = 4'd5; wdat[2] = 8'hFF; req[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b1;
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    chk("abort_ack_a", int'(ack[2]), 0);
    chk("abort_ack_b", int'(ack[3]), 0);
    chk("abort_data_a", int'(rdat[2]), 0);
    chk("abort_data_b", int'(rdat[3]), 0);
    wait_clear(1'b0);
    repeat (6) @(negedge clk);
`ifdef RAM_CLEAR_EN
    op(2, 1'b0, 4'd5, 8'h00, 4);
`else
    op(2, 1'b0, 4'd5, 8'h77, 4);
`endif

    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("sb_empty_ch%0d", i), sb[i].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
